// File: rtl/armleocpu_multiplier_ext_if.sv
// Request/response bundle of the iterative multiplier: an operand handshake,
// a result handshake and the flush (kill) strobe.
interface armleocpu_multiplier_ext_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [WIDTH-1:0]     in_factor0;
    logic [WIDTH-1:0]     in_factor1;
    logic                 kill;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [2*WIDTH-1:0]   out_product;

    modport master (
        output in_valid, in_op, in_factor0, in_factor1, kill, out_ready,
        input  in_ready, out_valid, out_result, out_product
    );

    modport slave (
        input  in_valid, in_op, in_factor0, in_factor1, kill, out_ready,
        output in_ready, out_valid, out_result, out_product
    );
endinterface

// File: rtl/armleocpu_multiplier_ext.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) working on
// magnitudes, with early exit once the remaining multiplier bits are zero.
module armleocpu_multiplier_ext #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    armleocpu_multiplier_ext_if.slave   mul
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam int W2    = 2 * WIDTH;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [W2-1:0]      a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [1:0]         op_q, op_d;

    logic               sign0, sign1;
    logic [WIDTH-1:0]   mag0, mag1;
    logic [W2-1:0]      partial;
    logic [WIDTH-1:0]   b_shift;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        // -2^(W-1) maps onto itself, which is the correct unsigned magnitude
        return neg ? WIDTH'(-sv) : v;
    endfunction

    function automatic logic [W2-1:0] negate(input logic [W2-1:0] v);
        logic signed [W2-1:0] sv;
        sv = v;
        return W2'(-sv);
    endfunction

    assign sign0   = ((mul.in_op == OP_MULH) || (mul.in_op == OP_MULHSU)) && mul.in_factor0[WIDTH-1];
    assign sign1   = (mul.in_op == OP_MULH) && mul.in_factor1[WIDTH-1];
    assign mag0    = magnitude(mul.in_factor0, sign0);
    assign mag1    = magnitude(mul.in_factor1, sign1);
    assign partial = a_q * W2'(b_q[BITS_PER_CYCLE-1:0]);
    assign b_shift = b_q >> BITS_PER_CYCLE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (mul.in_valid) begin
                    op_d  = mul.in_op;
                    neg_d = sign0 ^ sign1;
                    // Smaller magnitude drives the loop so early exit triggers sooner
                    if (mag1 > mag0) begin
                        a_d = {{WIDTH{1'b0}}, mag1};
                        b_d = mag0;
                    end else begin
                        a_d = {{WIDTH{1'b0}}, mag0};
                        b_d = mag1;
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + partial;
                a_d   = a_q << BITS_PER_CYCLE;
                b_d   = b_shift;
                cnt_d = cnt_q + 1'b1;
                if ((b_shift == '0) || (cnt_q == CNT_W'(STEPS - 1)))
                    state_d = SIGN;
            end
            SIGN: begin
                if (neg_q)
                    acc_d = negate(acc_q);
                state_d = DONE;
            end
            DONE: begin
                if (mul.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush wins over everything, including a same-cycle result accept
        if (mul.kill && (state_q != IDLE))
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            op_q    <= OP_MUL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign mul.in_ready    = (state_q == IDLE);
    assign mul.out_valid   = (state_q == DONE);
    assign mul.out_product = acc_q;
    assign mul.out_result  = (op_q == OP_MUL) ? acc_q[WIDTH-1:0] : acc_q[W2-1:WIDTH];

endmodule

// File: tb/tb_armleocpu_multiplier_ext.sv
// Bench for armleocpu_multiplier_ext: two instances (1 and 4 bits per cycle)
// share one stimulus stream; each has its own scoreboard queue and monitor.
module tb_armleocpu_multiplier_ext;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid, kill, out_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  f0, f1;

    armleocpu_multiplier_ext_if #(.WIDTH(W)) ifc1 ();
    armleocpu_multiplier_ext_if #(.WIDTH(W)) ifc4 ();

    assign ifc1.in_valid   = in_valid;
    assign ifc1.in_op      = in_op;
    assign ifc1.in_factor0 = f0;
    assign ifc1.in_factor1 = f1;
    assign ifc1.kill       = kill;
    assign ifc1.out_ready  = out_ready;
    assign ifc4.in_valid   = in_valid;
    assign ifc4.in_op      = in_op;
    assign ifc4.in_factor0 = f0;
    assign ifc4.in_factor1 = f1;
    assign ifc4.kill       = kill;
    assign ifc4.out_ready  = out_ready;

    armleocpu_multiplier_ext #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .mul(ifc1));
    armleocpu_multiplier_ext #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .mul(ifc4));

    typedef struct {
        logic [63:0] prod;
        logic [31:0] res;
        int          lat1;
        int          lat4;
        int          t;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    int   first1, first4;
    bit   seen1 = 0, seen4 = 0;
    int   n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) seen1 = 0;
        else if (ifc1.out_valid) begin
            if (!seen1) begin seen1 = 1; first1 = cyc; end
            if (ifc1.out_ready) begin
                seen1 = 0;
                if (q1.size() == 0) check("dut1 unexpected out_valid", 64'd1, 64'd0);
                else begin
                    e1 = q1.pop_front();
                    check("dut1 out_product", ifc1.out_product, e1.prod);
                    check("dut1 out_result", 64'(ifc1.out_result), 64'(e1.res));
                    check("dut1 latency", 64'(first1 - e1.t), 64'(e1.lat1));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) seen4 = 0;
        else if (ifc4.out_valid) begin
            if (!seen4) begin seen4 = 1; first4 = cyc; end
            if (ifc4.out_ready) begin
                seen4 = 0;
                if (q4.size() == 0) check("dut4 unexpected out_valid", 64'd1, 64'd0);
                else begin
                    e4 = q4.pop_front();
                    check("dut4 out_product", ifc4.out_product, e4.prod);
                    check("dut4 out_result", 64'(ifc4.out_result), 64'(e4.res));
                    check("dut4 latency", 64'(first4 - e4.t), 64'(e4.lat4));
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input logic [31:0] res,
                         input int l1, input int l4, input bit push);
        int k = 0;
        exp_t e;
        while (!(ifc1.in_ready && ifc4.in_ready) && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("in_ready before issue", 64'(ifc1.in_ready & ifc4.in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; f0 = a; f1 = b;
        if (push) begin
            e.prod = prod; e.res = res; e.lat1 = l1; e.lat4 = l4; e.t = cyc;
            q1.push_back(e);
            q4.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; f0 = ~a; f1 = ~b; in_op = ~op;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(ifc1.in_ready && ifc4.in_ready) && k < 100) begin
            @(posedge clk); #1; k++;
        end
    endtask

    initial begin
        int k;
        in_valid = 0; in_op = 0; f0 = 0; f1 = 0; kill = 0; out_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'({ifc1.out_valid, ifc4.out_valid}), 64'd0);
        check("reset in_ready", 64'({ifc1.in_ready, ifc4.in_ready}), 64'd3);
        check("reset out_product", ifc1.out_product | ifc4.out_product, 64'd0);
        check("reset out_result", 64'(ifc1.out_result | ifc4.out_result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 32'hFFFFFFFE, 34, 10, 1);
        issue(2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 32'h40000000, 34, 10, 1);
        issue(2'b01, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 32'hFFFFFFFF, 3, 3, 1);
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000001, 32'hFFFFFFFF, 3, 3, 1);
        issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB, 32'hFFFFFFEB, 5, 3, 1);
        issue(2'b01, 32'h00000000, 32'h80000000, 64'h0, 32'h0, 3, 3, 1);
        issue(2'b11, 32'h00000000, 32'hDEADBEEF, 64'h0, 32'h0, 3, 3, 1);
        issue(2'b10, 32'h80000000, 32'h00000003, 64'hFFFFFFFE_80000000, 32'hFFFFFFFE, 4, 3, 1);
        issue(2'b01, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 32'hFFFFFFFF, 4, 3, 1);

        // Back-pressure: result must hold in DONE while out_ready is low
        wait_idle();
        out_ready = 1'b0;
        issue(2'b11, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 32'h00000001, 19, 7, 1);
        k = 0;
        while (!ifc1.out_valid && k < 60) begin @(posedge clk); #1; k++; end
        check("hold reached DONE", 64'(ifc1.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold out_valid", 64'({ifc1.out_valid, ifc4.out_valid}), 64'd3);
            check("hold in_ready", 64'({ifc1.in_ready, ifc4.in_ready}), 64'd0);
            check("hold out_product", ifc1.out_product, 64'h00000001_00000000);
            check("hold out_result", 64'(ifc1.out_result), 64'h1);
            in_valid = 1'b1; in_op = 2'b00; f0 = 32'd9; f1 = 32'd9;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", 64'(ifc1.in_ready), 64'd1);
        issue(2'b00, 32'd3, 32'd5, 64'd15, 32'd15, 4, 3, 1);

        // Kill in the third CALC cycle
        wait_idle();
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill in_ready", 64'({ifc1.in_ready, ifc4.in_ready}), 64'd3);
        check("kill out_valid", 64'({ifc1.out_valid, ifc4.out_valid}), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("kill no late result", 64'({ifc1.out_valid, ifc4.out_valid}), 64'd0);

        // Asynchronous reset mid-CALC
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'({ifc1.out_valid, ifc4.out_valid}), 64'd0);
        check("async reset in_ready", 64'({ifc1.in_ready, ifc4.in_ready}), 64'd3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post reset in_ready", 64'({ifc1.in_ready, ifc4.in_ready}), 64'd3);
        issue(2'b00, 32'd3, 32'd5, 64'd15, 32'd15, 4, 3, 1);

        k = 0;
        while ((q1.size() + q4.size()) != 0 && k < 200) begin @(posedge clk); #1; k++; end
        check("scoreboard drained", 64'(q1.size() + q4.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
